// File: rtl/htd_arb.sv
// htd_arb: round-robin frame arbiter with head/tail delimited output and two-cycle latency
module htd_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_PORTS-1:0]            iv_req,
  output logic [NUM_PORTS-1:0]            ov_grant,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] iv_data,
  input  logic [NUM_PORTS-1:0]            iv_data_wr,
  output logic [DATA_WIDTH:0]             ov_data,
  output logic                            o_data_wr,
  output logic                            o_timeout
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, XFER = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] last, g, nxt, cand;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] buf_data, din;
  logic buf_head, wr_g;
  assign wr_g = iv_data_wr[g];
  assign din = iv_data[g*DATA_WIDTH +: DATA_WIDTH];
  always_comb begin
    nxt = last;
    cand = last;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = PW'((int'(last) + i) % NUM_PORTS);
      nxt = iv_req[cand] ? cand : nxt;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      ov_grant <= '0;
      ov_data <= '0;
      o_data_wr <= 1'b0;
      o_timeout <= 1'b0;
      last <= PW'(NUM_PORTS - 1);
      g <= '0;
      cnt <= '0;
      buf_data <= '0;
      buf_head <= 1'b0;
    end else begin
      o_data_wr <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: if (|iv_req) begin
          g <= nxt;
          last <= nxt;
          ov_grant <= NUM_PORTS'(1) << nxt;
          cnt <= '0;
          state <= GRANT;
        end
        GRANT: if (wr_g) begin
          buf_data <= din;
          buf_head <= 1'b1;
          state <= XFER;
        end else if (!iv_req[g]) begin
          ov_grant <= '0;
          state <= IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          ov_grant <= '0;
          o_timeout <= 1'b1;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        XFER: begin
          // the buffered word is the tail exactly when the granted port stops writing now
          ov_data <= {buf_head | ~wr_g, buf_data};
          o_data_wr <= 1'b1;
          if (wr_g) begin
            buf_data <= din;
            buf_head <= 1'b0;
          end else begin
            ov_grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_htd_arb.sv
// tb_htd_arb: directed vector table plus reactive sequences for htd_arb
module tb_htd_arb;
  logic i_clk, i_rst;
  logic [3:0] iv_req, ov_grant, iv_data_wr;
  logic [31:0] iv_data;
  logic [8:0] ov_data;
  logic o_data_wr, o_timeout;
  int n_chk, n_fail;
  int cnt_g3, to_cnt, to_bad, gap_err;
  logic hit;
  logic [3:0] gq[$];
  logic [8:0] oq[$];
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [3:0] wr;
    logic [31:0] data;
    logic [3:0] g;
    logic v;
    logic [8:0] d;
    logic to;
  } vec_t;
  vec_t tv[14];
  logic [3:0] exp_g034[4];
  logic [8:0] exp_o034[8];

  htd_arb #(.DATA_WIDTH(8), .NUM_PORTS(4), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .iv_req(iv_req), .ov_grant(ov_grant),
    .iv_data(iv_data), .iv_data_wr(iv_data_wr), .ov_data(ov_data),
    .o_data_wr(o_data_wr), .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_rst();
    @(negedge i_clk);
    i_rst = 1'b1;
    iv_req = '0;
    iv_data_wr = '0;
    iv_data = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // granted ports wait one cycle, then write nw words; junk ports write 0xBB every cycle
  task automatic run(input logic [3:0] rq, input logic [3:0] junk, input int nw, input int ncyc,
                     input logic [3:0] stop_g);
    int ph;
    logic [3:0] prev, w;
    logic [31:0] d;
    gq.delete();
    oq.delete();
    ph = 0;
    prev = '0;
    hit = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      if (o_data_wr) oq.push_back(ov_data);
      if (ov_grant == 4'b1000) cnt_g3++;
      if (o_timeout) begin
        to_cnt++;
        if (ov_grant != 0) to_bad++;
      end
      if (ov_grant != prev && ov_grant != 0) begin
        gq.push_back(ov_grant);
        if (prev != 0) gap_err++;
      end
      if (stop_g != 0 && ov_grant == stop_g) begin
        hit = 1'b1;
        break;
      end
      prev = ov_grant;
      ph = ov_grant == 0 ? 0 : ph + 1;
      w = junk;
      d = '0;
      for (int p = 0; p < 4; p++) begin
        if (junk[p]) d[p*8 +: 8] = 8'hBB;
        if (ov_grant[p] && ph >= 2 && ph <= nw + 1) begin
          w[p] = 1'b1;
          d[p*8 +: 8] = 8'(p * 16 + ph - 1);
        end
      end
      iv_req = rq;
      iv_data_wr = w;
      iv_data = d;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cnt_g3 = 0;
    to_cnt = 0;
    to_bad = 0;
    gap_err = 0;
    i_rst = 1'b1;
    iv_req = '0;
    iv_data_wr = '0;
    iv_data = '0;
    tv[0]  = '{1'b1, 4'h0, 4'h0, 32'h0,        4'h0, 1'b0, 9'h000, 1'b0};
    tv[1]  = '{1'b0, 4'h2, 4'h0, 32'h0,        4'h0, 1'b0, 9'h000, 1'b0};
    tv[2]  = '{1'b0, 4'h2, 4'h0, 32'h0,        4'h2, 1'b0, 9'h000, 1'b0};
    tv[3]  = '{1'b0, 4'h2, 4'h2, 32'h00001100, 4'h2, 1'b0, 9'h000, 1'b0};
    tv[4]  = '{1'b0, 4'h2, 4'h6, 32'h00EE2200, 4'h2, 1'b0, 9'h000, 1'b0};
    tv[5]  = '{1'b0, 4'h2, 4'h2, 32'h00003300, 4'h2, 1'b1, 9'h111, 1'b0};
    tv[6]  = '{1'b0, 4'h0, 4'h0, 32'h0,        4'h2, 1'b1, 9'h022, 1'b0};
    tv[7]  = '{1'b0, 4'h0, 4'h0, 32'h0,        4'h0, 1'b1, 9'h133, 1'b0};
    tv[8]  = '{1'b0, 4'h1, 4'h0, 32'h0,        4'h0, 1'b0, 9'h133, 1'b0};
    tv[9]  = '{1'b0, 4'h1, 4'h0, 32'h0,        4'h1, 1'b0, 9'h133, 1'b0};
    tv[10] = '{1'b0, 4'h1, 4'h1, 32'h0000005A, 4'h1, 1'b0, 9'h133, 1'b0};
    tv[11] = '{1'b0, 4'h0, 4'h0, 32'h0,        4'h1, 1'b0, 9'h133, 1'b0};
    tv[12] = '{1'b0, 4'h0, 4'h0, 32'h0,        4'h0, 1'b1, 9'h15A, 1'b0};
    tv[13] = '{1'b0, 4'h0, 4'h0, 32'h0,        4'h0, 1'b0, 9'h15A, 1'b0};
    exp_g034 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_o034 = '{9'h101, 9'h102, 9'h121, 9'h122, 9'h101, 9'h102, 9'h121, 9'h122};
    repeat (2) @(posedge i_clk);
    for (int k = 0; k < 14; k++) begin
      @(negedge i_clk);
      chk($sformatf("row%0d grant", k), 32'(ov_grant), 32'(tv[k].g));
      chk($sformatf("row%0d data_wr", k), 32'(o_data_wr), 32'(tv[k].v));
      chk($sformatf("row%0d data", k), 32'(ov_data), 32'(tv[k].d));
      chk($sformatf("row%0d timeout", k), 32'(o_timeout), 32'(tv[k].to));
      i_rst = tv[k].rst;
      iv_req = tv[k].req;
      iv_data_wr = tv[k].wr;
      iv_data = tv[k].data;
    end

    do_rst();
    gap_err = 0;
    run(4'b0101, 4'b0000, 2, 40, 4'b0000);
    chk("alt grant count", 32'(gq.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("alt grant%0d", k), 32'(k < gq.size() ? gq[k] : 4'hF), 32'(exp_g034[k]));
    chk("alt out count", 32'(oq.size() >= 8), 32'd1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("alt out%0d", k), 32'(k < oq.size() ? oq[k] : 9'h1FF), 32'(exp_o034[k]));
    chk("alt grant gap", 32'(gap_err), 32'd0);

    do_rst();
    cnt_g3 = 0;
    to_cnt = 0;
    to_bad = 0;
    run(4'b1000, 4'b0000, 0, 3, 4'b0000);
    run(4'b1010, 4'b0000, 0, 40, 4'b0010);
    chk("timeout next grant seen", 32'(hit), 32'd1);
    chk("timeout grant cycles", 32'(cnt_g3), 32'd15);
    chk("timeout pulses", 32'(to_cnt), 32'd1);
    chk("timeout with grant", 32'(to_bad), 32'd0);
    chk("timeout grant seq", 32'(gq.size() == 2 && gq[0] == 4'b1000), 32'd1);

    do_rst();
    gap_err = 0;
    run(4'b0011, 4'b0010, 3, 30, 4'b0010);
    chk("block port1 granted", 32'(hit), 32'd1);
    chk("block out count", 32'(oq.size()), 32'd3);
    chk("block out0", 32'(oq.size() > 0 ? oq[0] : 9'h1FF), 32'h101);
    chk("block out1", 32'(oq.size() > 1 ? oq[1] : 9'h1FF), 32'h002);
    chk("block out2", 32'(oq.size() > 2 ? oq[2] : 9'h1FF), 32'h103);
    chk("block grant gap", 32'(gap_err), 32'd0);

    do_rst();
    run(4'b0001, 4'b0000, 4, 3, 4'b0000);
    @(negedge i_clk);
    i_rst = 1'b1;
    iv_data_wr = 4'b0001;
    iv_data = 32'h00000002;
    @(negedge i_clk);
    chk("rst grant", 32'(ov_grant), 32'd0);
    chk("rst data_wr", 32'(o_data_wr), 32'd0);
    chk("rst data", 32'(ov_data), 32'd0);
    i_rst = 1'b0;
    iv_data_wr = '0;
    iv_data = '0;
    run(4'b0011, 4'b0000, 0, 8, 4'b0000);
    chk("rst no output", 32'(oq.size()), 32'd0);
    chk("rst next grant", 32'(gq.size() > 0 ? gq[0] : 4'hF), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
